// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the configuration-chain loader.
//   state_e     : loader FSM states (CHECK is only entered when readback is built in)
//   CRC8_POLY   : CRC-8 polynomial x^8 + x^2 + x + 1
//   CRC8_INIT   : CRC-8 start value
//   cnt_width() : width of an unsigned counter that holds 0..n
//   crc8_step() : one serial CRC-8 update, MSB-first
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Bitstream word handshake into the loader.
//   cfg_data  : bitstream word, bit [WORD_W-1] shifted first
//   cfg_valid : driven by the master, cfg_data is valid
//   cfg_ready : driven by the loader, a word can be accepted
// Handshake: a word is transferred on every clock edge where cfg_valid and
// cfg_ready are both high; the master holds cfg_data stable while cfg_valid
// is high and not yet accepted; cfg_ready never depends on cfg_valid.
interface ccff_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_crc8.sv
// Serial CRC-8 register (poly 0x07), one bit per enabled clock.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : reload the init value (wins over en)
//   en         : fold din into the CRC
//   din        : serial data bit
//   crc        : current CRC value
module ccff_crc8
    import fpga_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC8_INIT;
        end else if (clr) begin
            crc <= CRC8_INIT;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end
endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain writer: accepts bitstream words on cfg and serializes
// them MSB-first onto ccff_head with one ccff_shift_en pulse per bit.
//   prog_clk, prog_rst_n : clock, asynchronous active-low reset
//   start                : one-cycle pulse beginning a load (ignored while busy)
//   cfg                  : word handshake (slave side)
//   ccff_head            : serial data into the chain
//   ccff_shift_en        : chain shifts on the prog_clk edge where this is high
//   ccff_tail            : serial data out of the chain (readback only)
//   busy, done, err      : load in progress, completion pulse, sticky error
//   state_dbg            : current FSM state
// Optional: CCFF_READBACK_EN adds a CHECK pass that recirculates the chain
// once through ccff_tail and compares CRC-8 of written and read bits.
module ccff_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int WORD_W    = 8
) (
    input  logic          prog_clk,
    input  logic          prog_rst_n,
    input  logic          start,
    ccff_loader_if.slave  cfg,
    output logic          ccff_head,
    output logic          ccff_shift_en,
    input  logic          ccff_tail,
    output logic          busy,
    output logic          done,
    output logic          err,
    output state_e        state_dbg
);
    localparam int CNT_W = cnt_width(CHAIN_LEN);
    localparam int BIT_W = cnt_width(WORD_W);

    state_e            state, state_next;
    logic [CNT_W-1:0]  bits_left;
    logic [BIT_W-1:0]  bit_idx;
    logic [WORD_W-1:0] shreg;
    logic              head_q;
    logic              en_q;
    logic              last_bit;
    logic              word_end;

    // The bit on ccff_head this cycle is the last of the chain / of the word.
    assign last_bit = (bits_left == CNT_W'(1));
    assign word_end = (bit_idx == BIT_W'(WORD_W - 1)) || last_bit;

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: if (cfg.cfg_valid) state_next = SHIFT;
            SHIFT: begin
                if (word_end) begin
                    if (last_bit) begin
`ifdef CCFF_READBACK_EN
                        state_next = CHECK;
`else
                        state_next = FIN;
`endif
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            CHECK: if (last_bit) state_next = FIN;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // head_q/en_q are loaded one edge ahead so they line up with the SHIFT
    // cycles: the word's MSB is presented on the edge that captures it.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            bits_left <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            head_q    <= 1'b0;
            en_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) bits_left <= CNT_W'(CHAIN_LEN);
                end
                FETCH: begin
                    if (cfg.cfg_valid) begin
                        shreg   <= cfg.cfg_data << 1;
                        head_q  <= cfg.cfg_data[WORD_W-1];
                        en_q    <= 1'b1;
                        bit_idx <= '0;
                    end
                end
                SHIFT: begin
                    bits_left <= bits_left - CNT_W'(1);
                    bit_idx   <= bit_idx + BIT_W'(1);
                    if (word_end) begin
                        head_q <= 1'b0;
                        en_q   <= 1'b0;
`ifdef CCFF_READBACK_EN
                        // Reuse the counter to time one full recirculation.
                        if (last_bit) bits_left <= CNT_W'(CHAIN_LEN);
`endif
                    end else begin
                        head_q <= shreg[WORD_W-1];
                        shreg  <= shreg << 1;
                    end
                end
                CHECK: bits_left <= bits_left - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign cfg.cfg_ready = (state == FETCH);
    assign busy          = (state == FETCH) || (state == SHIFT) || (state == CHECK);
    assign done          = (state == FIN);
    assign state_dbg     = state;

`ifdef CCFF_READBACK_EN
    logic [7:0] crc_tx;
    logic [7:0] crc_rx;
    logic       crc_clr;
    logic       err_q;

    assign crc_clr = (state == IDLE) && start;

    ccff_crc8 u_crc_tx (
        .clk   (prog_clk),
        .rst_n (prog_rst_n),
        .clr   (crc_clr),
        .en    (state == SHIFT),
        .din   (head_q),
        .crc   (crc_tx)
    );

    ccff_crc8 u_crc_rx (
        .clk   (prog_clk),
        .rst_n (prog_rst_n),
        .clr   (crc_clr),
        .en    (state == CHECK),
        .din   (ccff_tail),
        .crc   (crc_rx)
    );

    // Compare against the rx CRC including the final tail bit so err is
    // already valid in the FIN cycle alongside done.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            err_q <= 1'b0;
        end else if (crc_clr) begin
            err_q <= 1'b0;
        end else if ((state == CHECK) && last_bit &&
                     (crc_tx != crc8_step(crc_rx, ccff_tail))) begin
            err_q <= 1'b1;
        end
    end

    // During CHECK the chain output is fed straight back into its input.
    assign ccff_head     = (state == CHECK) ? ccff_tail : head_q;
    assign ccff_shift_en = en_q || (state == CHECK);
    assign err           = err_q;
`else
    logic unused_tail;
    assign unused_tail   = ccff_tail;
    assign ccff_head     = head_q;
    assign ccff_shift_en = en_q;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
module tb_ccff_loader;
  import fpga_cfg_pkg::*;

`ifdef CCFF_READBACK_EN
  localparam int RB32 = 32;
  localparam int RB30 = 30;
`else
  localparam int RB32 = 0;
  localparam int RB30 = 0;
`endif

  typedef struct {
    logic [31:0] words;
    int          stall;
    logic [31:0] chain32;
    logic [29:0] chain30;
    int          lat32;
    int          lat30;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;

  ccff_loader_if #(.WORD_W(8)) if32 ();
  ccff_loader_if #(.WORD_W(8)) if30 ();
  assign if32.cfg_data  = data;
  assign if32.cfg_valid = valid;
  assign if30.cfg_data  = data;
  assign if30.cfg_valid = valid;

  logic head32, en32, busy32, done32, err32;
  logic head30, en30, busy30, done30, err30;
  state_e st32, st30;
  logic [31:0] chain32 = '0;
  logic [29:0] chain30 = '0;

  ccff_loader #(.CHAIN_LEN(32), .WORD_W(8)) dut32 (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .cfg(if32),
    .ccff_head(head32), .ccff_shift_en(en32), .ccff_tail(chain32[31]),
    .busy(busy32), .done(done32), .err(err32), .state_dbg(st32)
  );

  ccff_loader #(.CHAIN_LEN(30), .WORD_W(8)) dut30 (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .cfg(if30),
    .ccff_head(head30), .ccff_shift_en(en30), .ccff_tail(chain30[29]),
    .busy(busy30), .done(done30), .err(err30), .state_dbg(st30)
  );

  // ---------------- chain models (flops clocked like the real chain) ----------------
  bit flip_arm = 1'b0;
  bit flip32 = 1'b0;

  always @(posedge clk) begin
    logic [31:0] nxt;
    nxt = en32 ? {chain32[30:0], head32} : chain32;
    if (flip32) nxt[5] = ~nxt[5];
    chain32 <= nxt;
    if (en30) chain30 <= {chain30[28:0], head30};
  end

  always @(negedge clk) begin
    flip32 = 1'b0;
    if (flip_arm && st32 == CHECK) begin
      flip32 = 1'b1;
      flip_arm = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_miss = 0;
  logic [0:0] exp32_q[$];
  logic [0:0] exp30_q[$];
  int pulses32 = 0;
  int pulses30 = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic sb_fail(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: shift pulse with no expected bit queued (t=%0t)", nm, $time);
  endtask

  always @(negedge clk) begin
    logic [0:0] b;
    if (en32 && st32 != CHECK) begin
      pulses32++;
      if (exp32_q.size() == 0) sb_fail("head32_extra");
      else begin
        b = exp32_q.pop_front();
        check("head32_bit", head32, b);
      end
    end
    if (en30 && st30 != CHECK) begin
      pulses30++;
      if (exp30_q.size() == 0) sb_fail("head30_extra");
      else begin
        b = exp30_q.pop_front();
        check("head30_bit", head30, b);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic push_word(input logic [7:0] wd, inout int rem, input bit is32);
    for (int b = 7; b >= 0; b--) begin
      if (rem > 0) begin
        if (is32) exp32_q.push_back(wd[b]);
        else      exp30_q.push_back(wd[b]);
        rem--;
      end
    end
  endtask

  task automatic run_load(input logic [31:0] words, input int stall, input int abort_at,
                          output int l32, output int l30, output int sp, output int late);
    int wi32, wi30, rem32, rem30, stall_cnt, seen;
    wi32 = 0; wi30 = 0; rem32 = 32; rem30 = 30; stall_cnt = 0; seen = 0;
    l32 = -1; l30 = -1; sp = 0; late = 0;
    pulses32 = 0; pulses30 = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy32_first_fetch", busy32, 1'b1);
    check("err32_cleared_on_start", err32, 1'b0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (abort_at > 0 && en32) begin
        seen++;
        if (seen == abort_at) begin
          rst_n = 1'b0;
          return;
        end
      end
      if (done32 && l32 < 0) l32 = cyc;
      if (done30 && l30 < 0) l30 = cyc;
      if (l32 >= 0 && l30 >= 0) break;
      start = (cyc == 10);  // stray start mid-load must be ignored
      valid = !(wi32 == 2 && stall_cnt < stall);
      data  = (wi32 < 4) ? words[8*(3-wi32) +: 8] : 8'h00;
      if (wi32 == 2 && stall_cnt < stall && if32.cfg_ready) begin
        stall_cnt++;
        if (en32) sp++;
      end
      if (if32.cfg_ready && valid && wi32 < 4) begin
        push_word(words[8*(3-wi32) +: 8], rem32, 1'b1);
        wi32++;
      end
      if (if30.cfg_ready) begin
        if (wi30 >= 4) late++;
        else if (valid) begin
          push_word(words[8*(3-wi30) +: 8], rem30, 1'b0);
          wi30++;
        end
      end
    end
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic verify(input vec_t v, input bit exp_err, input int l32, input int l30,
                        input int sp, input int late);
    check("done32_latency", l32, v.lat32 + RB32);
    check("done30_latency", l30, v.lat30 + RB30);
    if (!exp_err) check("chain32_contents", chain32, v.chain32);
    check("chain30_contents", chain30, v.chain30);
    check("pulses32", pulses32, 32);
    check("pulses30", pulses30, 30);
    check("exp32_q_left", exp32_q.size(), 0);
    check("exp30_q_left", exp30_q.size(), 0);
    check("err32", err32, exp_err);
    check("err30", err30, 1'b0);
    check("ready30_after_last_word", late, 0);
    check("shift_during_stall", sp, 0);
    @(negedge clk);
    check("done32_one_cycle", done32, 1'b0);
    check("busy32_after_done", busy32, 1'b0);
    check("ready32_after_done", if32.cfg_ready, 1'b0);
    check("state32_idle", st32, IDLE);
  endtask

  // ---------------- test ----------------
  vec_t vt[5];
  int l32, l30, sp, late;
  logic [31:0] rw;

  initial begin
    rw = $urandom();
    vt[0] = '{32'hA53CFF00, 0, 32'hA53CFF00, {8'hA5, 8'h3C, 8'hFF, 6'h00}, 36, 34};
    vt[1] = '{32'h112233FF, 0, 32'h112233FF, {8'h11, 8'h22, 8'h33, 6'h3F}, 36, 34};
    vt[2] = '{32'hA53CFF00, 5, 32'hA53CFF00, {8'hA5, 8'h3C, 8'hFF, 6'h00}, 41, 39};
    vt[3] = '{32'hC35A0FF0, 2, 32'hC35A0FF0, {8'hC3, 8'h5A, 8'h0F, 6'h3C}, 38, 36};
    vt[4] = '{rw, $urandom_range(0, 7), rw, rw[31:2], 36, 34};
    vt[4].lat32 = 36 + vt[4].stall;
    vt[4].lat30 = 34 + vt[4].stall;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_shift_en", en32, 1'b0);
    check("rst_head", head32, 1'b0);
    check("rst_busy", busy32, 1'b0);
    check("rst_done", done32, 1'b0);
    check("rst_err", err32, 1'b0);
    check("rst_ready", if32.cfg_ready, 1'b0);
    check("rst_state", st32, IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // table-driven loads
    for (int i = 0; i < 5; i++) begin
      run_load(vt[i].words, vt[i].stall, 0, l32, l30, sp, late);
      verify(vt[i], 1'b0, l32, l30, sp, late);
    end

    // reset after 13 shifted bits, then a clean reload
    run_load(32'hA53CFF00, 0, 13, l32, l30, sp, late);
    @(negedge clk);
    check("abort_shift_en", en32, 1'b0);
    check("abort_busy", busy32, 1'b0);
    check("abort_ready", if32.cfg_ready, 1'b0);
    check("abort_done", done32, 1'b0);
    check("abort_state", st32, IDLE);
    rst_n = 1'b1;
    exp32_q.delete();
    exp30_q.delete();
    @(negedge clk);
    run_load(vt[0].words, 0, 0, l32, l30, sp, late);
    verify(vt[0], 1'b0, l32, l30, sp, late);

`ifdef CCFF_READBACK_EN
    // corrupt one chain bit during CHECK: err must rise and stay until next start
    flip_arm = 1'b1;
    run_load(vt[1].words, 0, 0, l32, l30, sp, late);
    verify(vt[1], 1'b1, l32, l30, sp, late);
    repeat (3) @(negedge clk);
    check("err32_sticky", err32, 1'b1);
    run_load(vt[0].words, 0, 0, l32, l30, sp, late);
    verify(vt[0], 1'b0, l32, l30, sp, late);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
